// File: rtl/counter_if.sv
// Row-counter bus: the row length going in, the remaining-element and
// zero-row counts coming back. The master drives rowLength; the counter
// sits on the slave side and drives both counts.
interface counter_if;
  logic [4:0] rowLength;
  logic [4:0] count;
  logic [4:0] countZero;

  modport master (
    output rowLength,
    input  count,
    input  countZero
  );

  modport slave (
    input  rowLength,
    output count,
    output countZero
  );
endinterface

// File: rtl/counter.sv
// Row counter: loads a row length whenever the current row is exhausted or
// on its last element, counts down through the row, and keeps a wrapping
// tally of zero-length rows seen since reset.
module counter (
  input  logic     clk,
  input  logic     reset,
  counter_if.slave bus
);

  logic [4:0] r_count;
  logic [4:0] r_countZero;
  logic       w_load;
  logic       w_zeroRow;

  // A row ends when count is 0 (nothing loaded) or 1 (last element); both
  // reload so consecutive rows run back to back without a 0 in between.
  assign w_load    = (r_count == 5'd0) || (r_count == 5'd1);
  assign w_zeroRow = (bus.rowLength == 5'd0);

  // Reset beats load and decrement; load samples rowLength, otherwise step down.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count     <= 5'd0;
      r_countZero <= 5'd0;
    end else if (w_load) begin
      r_count <= bus.rowLength;
      if (w_zeroRow) begin
        r_countZero <= r_countZero + 5'd1;
      end
    end else begin
      r_count <= r_count - 5'd1;
    end
  end

  assign bus.count     = r_count;
  assign bus.countZero = r_countZero;

endmodule

// File: tb/tb_counter.sv
// Bench for the row counter: directed rows covering reset, reload, zero rows
// and wrap, then randomized row lengths checked against a row-level model.
module tb_counter;

  logic clk = 1'b0;
  logic reset;

  counter_if bus ();

  counter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model state: elements still left in the current row, and zero rows seen.
  int rowLeft  = 0;
  int zeroRows = 0;

  // Compares one observed value against its expected value and tallies it.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0d expected=%0d at %0t",
               tag, observed, expected, $time);
    end
  endtask

  // Row-level reference: a row of length L shows L, L-1, ..., 1 then the
  // next row starts; a row of length 0 shows 0 for one edge and is tallied.
  function automatic void modelEdge(input logic rst, input int len);
    if (rst) begin
      rowLeft  = 0;
      zeroRows = 0;
    end else if (rowLeft <= 1) begin
      rowLeft = len;
      if (len == 0) zeroRows = (zeroRows + 1) % 32;
    end else begin
      rowLeft = rowLeft - 1;
    end
  endfunction

  // Drives one edge's inputs, advances the model, then checks both outputs.
  task automatic applyStimulus(input logic rst, input int len);
    logic [4:0] lenBits;
    lenBits       = len[4:0];
    reset         = rst;
    bus.rowLength = lenBits;
    @(posedge clk);
    modelEdge(rst, len);
    #1;
    checkOutput("count", {27'd0, bus.count}, rowLeft);
    checkOutput("countZero", {27'd0, bus.countZero}, zeroRows);
  endtask

  int seq4 [6] = '{4, 3, 2, 1, 4, 3};
  int len;
  logic rst;

  initial begin
    reset         = 1'b1;
    bus.rowLength = 5'd4;

    // Reset held with rowLength 4: both counts stay 0.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 4);
      checkOutput("resetCount", {27'd0, bus.count}, 32'd0);
    end

    // Release: 4,3,2,1,4,3 with countZero at 0.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 4);
      checkOutput("seq4", {27'd0, bus.count}, seq4[i]);
    end
    checkOutput("seq4Zero", {27'd0, bus.countZero}, 32'd0);

    // Row length changed 4 -> 1 mid-row: 2,1 then 1 forever.
    applyStimulus(1'b1, 4);
    applyStimulus(1'b0, 4);
    applyStimulus(1'b0, 4);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1);
    checkOutput("rowOneSteady", {27'd0, bus.count}, 32'd1);

    // Zero rows from reset: count 0, countZero 1..5.
    applyStimulus(1'b1, 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 0);
      checkOutput("zeroTally", {27'd0, bus.countZero}, i + 1);
    end

    // 33 zero-row loads from reset: wraps 31 -> 0 then reaches 1.
    applyStimulus(1'b1, 0);
    for (int i = 0; i < 32; i++) applyStimulus(1'b0, 0);
    checkOutput("zeroWrap", {27'd0, bus.countZero}, 32'd0);
    applyStimulus(1'b0, 0);
    checkOutput("zeroWrapPlusOne", {27'd0, bus.countZero}, 32'd1);

    // Reset mid-row (count 3, rowLength 7), then reload 7 on release.
    applyStimulus(1'b1, 7);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 7);
    checkOutput("midRowCount", {27'd0, bus.count}, 32'd3);
    applyStimulus(1'b1, 7);
    checkOutput("midRowReset", {27'd0, bus.count}, 32'd0);
    applyStimulus(1'b0, 7);
    checkOutput("reload7", {27'd0, bus.count}, 32'd7);

    // Longest row: 31 down to 1, then straight back to 31.
    applyStimulus(1'b1, 31);
    for (int i = 0; i < 31; i++) begin
      applyStimulus(1'b0, 31);
      checkOutput("row31", {27'd0, bus.count}, 31 - i);
    end
    applyStimulus(1'b0, 31);
    checkOutput("row31Reload", {27'd0, bus.count}, 32'd31);

    // Randomized rows, mostly short so loads happen often, with rare resets.
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 40) == 0);
      case ($urandom_range(0, 3))
        0:       len = 0;
        1:       len = 1;
        2:       len = $urandom_range(2, 6);
        default: len = $urandom_range(0, 31);
      endcase
      applyStimulus(rst, len);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/counter.md
COUNTER -- requirements
Module: counter

Interface
REQ-001 The block SHALL have exactly one clock and a synchronous, active-high reset; clock and reset are named clk and reset.
REQ-002 clk  input  1  rising-edge clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous active-high reset, sampled on posedge clk.
REQ-004 rowLength  input  5  unsigned length of the next row (0..31), sampled only on a load cycle.
REQ-005 count  output  5  registered count of elements remaining in the current row, including the current element.
REQ-006 countZero  output  5  registered running count of zero-length rows loaded since reset, modulo 32.
REQ-007 The block SHALL have no parameters; all widths are fixed at 5 bits.

Function
REQ-008 A load cycle SHALL be any non-reset posedge where count is 0 or 1 (current row exhausted or on its last element).
REQ-009 On a load cycle, count SHALL take the value of rowLength sampled at that edge.
REQ-010 On a load cycle with rowLength == 0, countZero SHALL increment by 1; on all other cycles countZero SHALL hold.
REQ-011 On a non-load, non-reset posedge (count >= 2), count SHALL decrement by exactly 1 and rowLength SHALL be ignored.
REQ-012 Latency: a rowLength applied before a load edge SHALL appear on count one cycle after that edge; there is no combinational path from rowLength to any output.
REQ-013 Row length 4 SHALL produce the repeating count sequence 4,3,2,1 (period 4 cycles) while rowLength stays 4.
REQ-014 Row length 1 SHALL produce count = 1 on every cycle, with a reload on every edge.
REQ-015 Row length 0 SHALL keep count at 0 and increment countZero on every edge while rowLength stays 0.
REQ-016 A rowLength change during a row (count >= 2) SHALL NOT affect count until the next load cycle.
REQ-017 countZero SHALL wrap from 31 to 0 with no saturation and no flag.
REQ-018 count SHALL never underflow; 0 is reached only by loading rowLength == 0 or by reset.

Reset
REQ-019 While reset is high at a posedge, count SHALL become 0 and countZero SHALL become 0, regardless of rowLength or current state.
REQ-020 Reset SHALL take priority over load and decrement on the same edge, including mid-row.
REQ-021 The first posedge after reset deasserts SHALL be a load cycle, because count is 0.

Verification
REQ-022 Reset held with rowLength = 4 -> count = 0 and countZero = 0 throughout; after release, count = 4,3,2,1,4,3,... on successive edges; countZero stays 0.
REQ-023 rowLength changed from 4 to 1 mid-row (count = 3) -> count continues 2,1 and then reads 1 on every subsequent edge.
REQ-024 rowLength = 0 for 5 edges from reset release -> count = 0 throughout; countZero = 1,2,3,4,5.
REQ-025 rowLength = 0 for 33 load edges -> countZero wraps 31 to 0 and then reaches 1.
REQ-026 reset asserted while count = 3 with rowLength = 7 -> next edge gives count = 0 and countZero = 0; first edge after release loads 7.
REQ-027 rowLength = 31 -> count = 31 down to 1 over 31 cycles, then reloads 31; no glitch to 0 between rows.
